// File: rtl/ghr_ckpt.sv
// Speculative global history register with a checkpoint queue of in-flight branches.
// Each branch saves the pre-shift history so a mispredict can rebuild it exactly.
module ghr_ckpt #(
    parameter int GHR_WIDTH  = 5,
    parameter int CKPT_DEPTH = 8,
    parameter int TAG_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    input  logic                 pred_taken,
    output logic                 pred_ready,
    output logic [TAG_WIDTH-1:0] pred_tag,
    input  logic                 resolve_valid,
    input  logic [TAG_WIDTH-1:0] resolve_tag,
    input  logic                 resolve_taken,
    input  logic                 commit_valid,
    input  logic                 commit_taken,
    input  logic                 flush,
    output logic [GHR_WIDTH-1:0] ghr_spec,
    output logic [GHR_WIDTH-1:0] ghr_arch,
    output logic [TAG_WIDTH:0]   ckpt_count,
    output logic                 empty
);

    localparam int CW = TAG_WIDTH + 1;

    logic [GHR_WIDTH-1:0] ckpt_mem [CKPT_DEPTH];

    logic [GHR_WIDTH-1:0] ghr_spec_reg, ghr_spec_next;
    logic [GHR_WIDTH-1:0] ghr_arch_reg, ghr_arch_next;
    logic [TAG_WIDTH-1:0] head_reg, head_next;
    logic [TAG_WIDTH-1:0] tail_reg, tail_next;
    logic [CW-1:0]        count_reg, count_next;

    logic                 full;
    logic                 pred_fire;
    logic                 commit_fire;
    logic [TAG_WIDTH-1:0] resolve_dist;
    logic [GHR_WIDTH-1:0] resolve_ckpt;

    assign full         = (count_reg == CW'(CKPT_DEPTH));
    assign commit_fire  = commit_valid && (count_reg != '0);
    // A predict arriving alongside a redirect belongs to the wrong path and is dropped.
    assign pred_fire    = pred_valid && !full && !resolve_valid && !flush;
    assign resolve_dist = resolve_tag - head_reg;
    assign resolve_ckpt = ckpt_mem[resolve_tag];

    always_comb begin
        head_next     = head_reg;
        ghr_arch_next = ghr_arch_reg;
        if (commit_fire) begin
            head_next     = head_reg + TAG_WIDTH'(1);
            ghr_arch_next = {ghr_arch_reg[GHR_WIDTH-2:0], commit_taken};
        end
    end

    always_comb begin
        ghr_spec_next = ghr_spec_reg;
        tail_next     = tail_reg;
        count_next    = count_reg - CW'(commit_fire);
        if (flush) begin
            // Restore from committed history including this cycle's retirement.
            ghr_spec_next = ghr_arch_next;
            tail_next     = head_next;
            count_next    = '0;
        end else if (resolve_valid) begin
            ghr_spec_next = {resolve_ckpt[GHR_WIDTH-2:0], resolve_taken};
            tail_next     = resolve_tag + TAG_WIDTH'(1);
            count_next    = CW'(resolve_dist) + CW'(1) - CW'(commit_fire);
        end else if (pred_fire) begin
            ghr_spec_next = {ghr_spec_reg[GHR_WIDTH-2:0], pred_taken};
            tail_next     = tail_reg + TAG_WIDTH'(1);
            count_next    = count_reg + CW'(1) - CW'(commit_fire);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ghr_spec_reg <= '0;
            ghr_arch_reg <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
        end else begin
            ghr_spec_reg <= ghr_spec_next;
            ghr_arch_reg <= ghr_arch_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
        end
    end

    // Checkpoint contents need no reset; a slot is always written before it is read.
    always_ff @(posedge clk) begin
        if (pred_fire) begin
            ckpt_mem[tail_reg] <= ghr_spec_reg;
        end
    end

    assign ghr_spec   = ghr_spec_reg;
    assign ghr_arch   = ghr_arch_reg;
    assign ckpt_count = count_reg;
    assign empty      = (count_reg == '0);
    assign pred_ready = !full;
    assign pred_tag   = tail_reg;

endmodule

// File: tb/tb_ghr_ckpt.sv
// Directed-vector bench for ghr_ckpt (GHR_WIDTH=5, CKPT_DEPTH=4) with a queue-based scoreboard.
// The driver pushes expected state per step; a monitor pops and compares on the falling edge.
module tb_ghr_ckpt;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pred_valid = 1'b0, pred_taken = 1'b0;
    logic       pred_ready;
    logic [1:0] pred_tag;
    logic       resolve_valid = 1'b0;
    logic [1:0] resolve_tag = 2'd0;
    logic       resolve_taken = 1'b0;
    logic       commit_valid = 1'b0, commit_taken = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] ghr_spec, ghr_arch;
    logic [2:0] ckpt_count;
    logic       empty;

    ghr_ckpt #(.GHR_WIDTH(5), .CKPT_DEPTH(4), .TAG_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .pred_tag(pred_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_taken(resolve_taken),
        .commit_valid(commit_valid), .commit_taken(commit_taken),
        .flush(flush),
        .ghr_spec(ghr_spec), .ghr_arch(ghr_arch),
        .ckpt_count(ckpt_count), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        int         at;
        bit         now;
        logic [4:0] spec;
        logic [4:0] arch;
        logic [2:0] cnt;
        logic [1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    event async_ev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %0h expected %0h", nm, fld, act, req);
        end else begin
            $display("ok   %s %s = %0h", nm, fld, act);
        end
    endtask

    // Monitor: compares the DUT state against every expectation due at this point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or async_ev);
            while (exp_q.size() > 0 && (exp_q[0].now || exp_q[0].at <= cyc)) begin
                e = exp_q.pop_front();
                if (!e.now && e.at < cyc) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s stale: checked at cycle %0d expected cycle %0d", e.name, cyc, e.at);
                end
                check(e.name, "ghr_spec",   32'(ghr_spec),   32'(e.spec));
                check(e.name, "ghr_arch",   32'(ghr_arch),   32'(e.arch));
                check(e.name, "ckpt_count", 32'(ckpt_count), 32'(e.cnt));
                check(e.name, "empty",      32'(empty),      32'(e.cnt == 3'd0));
                check(e.name, "pred_ready", 32'(pred_ready), 32'(e.cnt != 3'd4));
                check(e.name, "pred_tag",   32'(pred_tag),   32'(e.tag));
            end
        end
    end

    // Protocol check: retiring with nothing in flight is illegal stimulus.
    always @(posedge clk) begin
        if (rst && commit_valid && empty) begin
            n_checks++;
            n_fail++;
            $display("FAIL commit_while_empty: got commit_valid=1 expected 0 at cycle %0d", cyc);
        end
    end

    task automatic step(input string nm,
                        input logic pv, input logic pt,
                        input logic rv, input logic [1:0] rtg, input logic rt,
                        input logic cv, input logic ct, input logic fl,
                        input logic [4:0] es, input logic [4:0] ea,
                        input logic [2:0] ec, input logic [1:0] et);
        exp_t e;
        @(negedge clk);
        pred_valid = pv; pred_taken = pt;
        resolve_valid = rv; resolve_tag = rtg; resolve_taken = rt;
        commit_valid = cv; commit_taken = ct; flush = fl;
        e.name = nm; e.at = cyc + 1; e.now = 1'b0;
        e.spec = es; e.arch = ea; e.cnt = ec; e.tag = et;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        pred_valid = 1'b0; pred_taken = 1'b0;
        resolve_valid = 1'b0; resolve_tag = 2'd0; resolve_taken = 1'b0;
        commit_valid = 1'b0; commit_taken = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    logic [4:0] wrap_v [7] = '{5'b00000, 5'b00001, 5'b00010, 5'b00101, 5'b01011, 5'b10110, 5'b01101};
    logic       wrap_b [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        exp_t e;
        int   wait_cnt;
        @(negedge clk);
        #2 rst = 1'b1;
        //    name            pv pt rv tag rt cv ct fl  spec      arch      cnt   tag
        step("reset_state",   0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 3'd0, 2'd0);
        step("pred1_T",       1, 1, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 3'd1, 2'd1);
        step("pred2_N",       1, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 5'b00000, 3'd2, 2'd2);
        step("pred3_T",       1, 1, 0, 0, 0, 0, 0, 0, 5'b00101, 5'b00000, 3'd3, 2'd3);
        step("pred4_T_full",  1, 1, 0, 0, 0, 0, 0, 0, 5'b01011, 5'b00000, 3'd4, 2'd0);
        step("pred5_ignored", 1, 1, 0, 0, 0, 0, 0, 0, 5'b01011, 5'b00000, 3'd4, 2'd0);
        step("resolve_t1_T",  0, 0, 1, 1, 1, 0, 0, 0, 5'b00011, 5'b00000, 3'd2, 2'd2);
        step("res0_pred_cmt", 1, 1, 1, 0, 0, 1, 1, 0, 5'b00000, 5'b00001, 3'd0, 2'd1);

        do_reset();
        step("reset2_state",  0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 3'd0, 2'd0);
        step("fl_pred1_T",    1, 1, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00000, 3'd1, 2'd1);
        step("fl_pred2_N",    1, 0, 0, 0, 0, 0, 0, 0, 5'b00010, 5'b00000, 3'd2, 2'd2);
        step("fl_pred3_T",    1, 1, 0, 0, 0, 0, 0, 0, 5'b00101, 5'b00000, 3'd3, 2'd3);
        step("commit1_T",     0, 0, 0, 0, 0, 1, 1, 0, 5'b00101, 5'b00001, 3'd2, 2'd3);
        step("commit2_T",     0, 0, 0, 0, 0, 1, 1, 0, 5'b00101, 5'b00011, 3'd1, 2'd3);
        step("flush_1_left",  0, 0, 0, 0, 0, 0, 0, 1, 5'b00011, 5'b00011, 3'd0, 2'd2);

        do_reset();
        step("reset3_state",  0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 3'd0, 2'd0);
        for (int k = 1; k <= 6; k++) begin
            step($sformatf("wrap_pred%0d", k), 1, wrap_b[k-1], 0, 0, 0, 0, 0, 0,
                 wrap_v[k], wrap_v[k-1], 3'd1, 2'(k));
            step($sformatf("wrap_cmt%0d", k), 0, 0, 0, 0, 0, 1, wrap_b[k-1], 0,
                 wrap_v[k], wrap_v[k], 3'd0, 2'(k));
        end
        step("pre_async_pred", 1, 1, 0, 0, 0, 0, 0, 0, 5'b11011, 5'b01101, 3'd1, 2'd3);

        // Drop reset between clock edges and check without any edge in between.
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        e.name = "async_reset"; e.at = cyc; e.now = 1'b1;
        e.spec = 5'b00000; e.arch = 5'b00000; e.cnt = 3'd0; e.tag = 2'd0;
        exp_q.push_back(e);
        -> async_ev;
        @(negedge clk);
        #2 rst = 1'b1;

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no completion expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
